// File: rtl/mem_test_sequencer_if.sv
// Memory master bus between the test sequencer and the memory slave.
// Avalon-MM style: a request is held with a stable address until a cycle
// with mem_waitrequest low; read data returns later on mem_readdatavalid.
interface mem_test_sequencer_if #(
  parameter int unsigned ADDR_W = 25
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic              mem_read;
  logic              mem_waitrequest;
  logic              mem_readdatavalid;

  modport master (
    output mem_addr, mem_write, mem_read,
    input  mem_waitrequest, mem_readdatavalid
  );

  modport slave (
    input  mem_addr, mem_write, mem_read,
    output mem_waitrequest, mem_readdatavalid
  );
endinterface

// File: rtl/mem_test_sequencer.sv
// Memory-check test sequencer: on a start pulse it loads the address
// generator, issues write and/or read transactions per address, steps the
// generator, counts completed addresses and pulses done at the end.
// Optional read-data watchdog: define MEM_SEQ_TIMEOUT_EN to enable it.
module mem_test_sequencer #(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 test_start_i,
  input  logic [1:0]           test_mode_i,
  input  logic [CNT_W-1:0]     trans_num_i,
  input  logic                 abort_i,
  input  logic [ADDR_W-1:0]    addr_i,
  output logic                 addr_load_o,
  output logic                 next_addr_en_o,
  mem_test_sequencer_if.master mem,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [CNT_W-1:0]     trans_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_ISSUE_RD,
    S_WAIT_RD,
    S_STEP,
    S_FINISH
  } state_e;

  // Mode 3 is folded into write-only when latched, so only three remain.
  typedef enum logic [1:0] {
    MODE_WR    = 2'd0,
    MODE_RD    = 2'd1,
    MODE_WR_RD = 2'd2
  } mode_e;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                abort_q, abort_d;
  logic                timeout_q, timeout_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                first_q, first_d;
  logic                wdog_expired;

  logic                addr_load;
  logic                next_addr_en;
  logic                wr_req;
  logic                rd_req;
  logic                done;

  assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int unsigned WDOG_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Watchdog counts cycles spent in WAIT_RD; any other state rearms it.
  always_comb begin
    wdog_d = '0;
    if (state_q == S_WAIT_RD) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  // Watchdog register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign wdog_expired = (state_q == S_WAIT_RD) &&
                        (wdog_q == WDOG_W'(TIMEOUT_CYC - 1));
`else
  assign wdog_expired = 1'b0;
`endif

  // Next-state and output decode for the sequencing FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    mode_d       = mode_q;
    num_d        = num_q;
    cnt_d        = cnt_q;
    abort_d      = abort_q;
    timeout_d    = timeout_q;
    addr_d       = addr_q;
    first_d      = 1'b0;
    addr_load    = 1'b0;
    next_addr_en = 1'b0;
    wr_req       = 1'b0;
    rd_req       = 1'b0;
    done         = 1'b0;

    // Abort is remembered and honoured only at the next STEP boundary.
    if (state_q != S_IDLE && abort_i) begin
      abort_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (test_start_i) begin
          mode_d    = (test_mode_i == 2'd3) ? MODE_WR : mode_e'(test_mode_i);
          num_d     = trans_num_i;
          cnt_d     = '0;
          timeout_d = 1'b0;
          abort_d   = 1'b0;
          addr_load = 1'b1;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        if (num_q == '0) begin
          state_d = S_FINISH;
        end else begin
          first_d = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // The generator output is fresh only in the first ISSUE cycle;
        // capture it there and hold it for the rest of the transaction.
        if (first_q) begin
          addr_d = addr_i;
        end
        if (mode_q == MODE_RD) begin
          rd_req = 1'b1;
        end else begin
          wr_req = 1'b1;
        end
        if (!mem.mem_waitrequest) begin
          case (mode_q)
            MODE_RD:    state_d = S_WAIT_RD;
            MODE_WR_RD: state_d = S_ISSUE_RD;
            default:    state_d = S_STEP;
          endcase
        end
      end

      S_ISSUE_RD: begin
        rd_req = 1'b1;
        if (!mem.mem_waitrequest) begin
          state_d = S_WAIT_RD;
        end
      end

      S_WAIT_RD: begin
        if (mem.mem_readdatavalid) begin
          state_d = S_STEP;
        end else if (wdog_expired) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end
      end

      S_STEP: begin
        cnt_d = cnt_inc;
        if (cnt_inc == num_q || abort_q || abort_i) begin
          state_d = S_FINISH;
        end else begin
          next_addr_en = 1'b1;
          first_d      = 1'b1;
          state_d      = S_ISSUE;
        end
      end

      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and latched test configuration.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_WR;
      num_q     <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
      addr_q    <= '0;
      first_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      mode_q    <= mode_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
      addr_q    <= addr_d;
      first_q   <= first_d;
    end
  end

  assign mem.mem_addr    = (state_q == S_ISSUE && first_q) ? addr_i : addr_q;
  assign mem.mem_write   = wr_req;
  assign mem.mem_read    = rd_req;
  assign addr_load_o     = addr_load;
  assign next_addr_en_o  = next_addr_en;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = done;
  assign timeout_o       = timeout_q;
  assign trans_cnt_o     = cnt_q;

endmodule
